// File: rtl/sram_req_arbiter_if.sv
// Bundled SRAM-like signals for the inst/data requesters and the shared downstream port.
// The slave modport is the arbiter's view; master is the surrounding pipeline/bridge.
interface sram_req_arbiter_if;
  logic        inst_sram_req;
  logic        inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [31:0] inst_sram_addr;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_wdata;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;

  logic        data_sram_req;
  logic        data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [31:0] data_sram_addr;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_wdata;
  logic        data_sram_addr_ok;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;

  logic        mem_req;
  logic        mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;

  logic        resp_err;

  modport slave (
    input  inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_addr,
    input  inst_sram_wstrb, inst_sram_wdata,
    output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
    input  data_sram_req, data_sram_wr, data_sram_size, data_sram_addr,
    input  data_sram_wstrb, data_sram_wdata,
    output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata,
    output mem_req, mem_wr, mem_size, mem_addr, mem_wstrb, mem_wdata,
    input  mem_addr_ok, mem_data_ok, mem_rdata,
    output resp_err
  );

  modport master (
    output inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_addr,
    output inst_sram_wstrb, inst_sram_wdata,
    input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
    output data_sram_req, data_sram_wr, data_sram_size, data_sram_addr,
    output data_sram_wstrb, data_sram_wdata,
    input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata,
    input  mem_req, mem_wr, mem_size, mem_addr, mem_wstrb, mem_wdata,
    output mem_addr_ok, mem_data_ok, mem_rdata,
    input  resp_err
  );
endinterface

// File: rtl/sram_req_arbiter.sv
// Shares one SRAM-like port between inst fetch and data access: data-priority grant with a
// hold-until-accepted lock, and an order FIFO that routes in-order responses to their owner.
module sram_req_arbiter #(
  parameter int unsigned OUTSTANDING = 4,
  parameter int unsigned PTR_W       = 2
) (
  input logic             clk,
  input logic             reset,
  sram_req_arbiter_if.slave bus
);

  logic [PTR_W-1:0]       r_wr_ptr;
  logic [PTR_W-1:0]       r_rd_ptr;
  logic [PTR_W:0]         r_count;
  logic [OUTSTANDING-1:0] r_owner;
  logic                   r_lock;
  logic                   r_lock_owner;
  logic                   r_resp_err;

  logic w_grant_data;
  logic w_grant_req;
  logic w_full;
  logic w_mem_req;
  logic w_accept;
  logic w_pop;
  logic w_unexpected;
  logic w_head_data;

  // A locked requester keeps the port until its pending address phase is accepted.
  always_comb begin
    w_grant_data = 1'b0;
    w_grant_req  = 1'b0;
    if (r_lock) begin
      w_grant_data = r_lock_owner;
      w_grant_req  = r_lock_owner ? bus.data_sram_req : bus.inst_sram_req;
    end else if (bus.data_sram_req) begin
      w_grant_data = 1'b1;
      w_grant_req  = 1'b1;
    end else if (bus.inst_sram_req) begin
      w_grant_data = 1'b0;
      w_grant_req  = 1'b1;
    end
  end

  assign w_full       = (r_count == (PTR_W+1)'(OUTSTANDING));
  assign w_mem_req    = w_grant_req & ~w_full;
  assign w_accept     = w_mem_req & bus.mem_addr_ok;
  assign w_pop        = bus.mem_data_ok & (r_count != '0);
  assign w_unexpected = bus.mem_data_ok & (r_count == '0);
  assign w_head_data  = r_owner[r_rd_ptr];

  assign bus.mem_req   = w_mem_req;
  assign bus.mem_wr    = w_grant_data ? bus.data_sram_wr    : bus.inst_sram_wr;
  assign bus.mem_size  = w_grant_data ? bus.data_sram_size  : bus.inst_sram_size;
  assign bus.mem_addr  = w_grant_data ? bus.data_sram_addr  : bus.inst_sram_addr;
  assign bus.mem_wstrb = w_grant_data ? bus.data_sram_wstrb : bus.inst_sram_wstrb;
  assign bus.mem_wdata = w_grant_data ? bus.data_sram_wdata : bus.inst_sram_wdata;

  assign bus.inst_sram_addr_ok = w_accept & ~w_grant_data;
  assign bus.data_sram_addr_ok = w_accept &  w_grant_data;

  assign bus.inst_sram_data_ok = w_pop & ~w_head_data;
  assign bus.data_sram_data_ok = w_pop &  w_head_data;
  assign bus.inst_sram_rdata   = bus.mem_rdata;
  assign bus.data_sram_rdata   = bus.mem_rdata;

  assign bus.resp_err = r_resp_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_owner      <= '0;
      r_lock       <= 1'b0;
      r_lock_owner <= 1'b0;
      r_resp_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_owner[r_wr_ptr] <= w_grant_data;
        r_wr_ptr          <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
      // Lock only when the request is actually presented; a full stall re-arbitrates.
      if (w_accept) begin
        r_lock <= 1'b0;
      end else if (w_mem_req) begin
        r_lock       <= 1'b1;
        r_lock_owner <= w_grant_data;
      end
      if (w_unexpected) begin
        r_resp_err <= 1'b1;
      end
    end
  end

endmodule
